md_unit_ctrl: RTL
=================

// Module: md_unit_ctrl
// PURPOSE
//  E-stage multiply/divide sequencer for the pipelined MIPS core: accepts
//  mult/multu/div/divu/mfhi/mflo/mthi/mtlo, owns HI/LO, models fixed
//  multi-cycle latency with a counter FSM and raises a stall request for the
//  D stage while the unit is occupied. Sits beside the ALU in E.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu is accepted (>=1)
//  DIV_CYCLES   10  busy cycles after a div/divu is accepted (>=1)
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  e_md_op    in   4   E-stage op: 0 none,1 mult,2 multu,3 div,4 divu,
//                      5 mfhi,6 mflo,7 mthi,8 mtlo, 9-15 treated as none
//  e_rs       in   32  forwarded rs value in E
//  e_rt       in   32  forwarded rt value in E
//  d_is_md    in   1   D-stage instruction is any md op (1..8)
//  busy       out  1   multi-cycle operation in flight
//  start      out  1   combinational: e_md_op in 1..4 and FSM in IDLE
//  stall_req  out  1   combinational: d_is_md & (start | busy)
//  md_rdata   out  32  combinational: HI if e_md_op==5, LO if 6, else 0
//  hi, lo     out  32  architectural HI/LO registers
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-operation): state IDLE, counter 0, busy 0,
//    hi 0, lo 0, pending results discarded. Comb outputs follow inputs.
//  - FSM: IDLE -> BUSY on an edge with start=1; counter loaded with
//    MULT_CYCLES-1 or DIV_CYCLES-1. BUSY: counter decrements each edge; on
//    the edge where counter==0, hi/lo take pending results, state -> IDLE.
//  - Result: busy=1 for exactly N cycles after the accepting edge; hi/lo
//    change on the edge that drops busy; first mfhi/mflo may read in the
//    cycle after busy falls.
//  - Operands sampled and result computed at the accepting edge into
//    pending regs; later e_rs/e_rt changes are irrelevant.
//  - mult: signed 64-bit product; multu: unsigned; {hi,lo}=product.
//  - div: lo=quotient truncated toward zero, hi=remainder with sign of
//    dividend; divu unsigned. 0x80000000 / 0xFFFFFFFF (div) -> lo=0x80000000,
//    hi=0. Divisor 0 (div/divu): still busy DIV_CYCLES, hi/lo unchanged.
//  - mthi/mtlo: write e_rs into hi/lo on the edge, only when IDLE and not
//    in the same cycle as start (mutually exclusive by op encoding).
//  - Protocol violations (md op in E while busy) are ignored: no start, no
//    write, md_rdata still returns current hi/lo. Pipeline prevents these.
//  - stall_req covers the back-to-back case: mult in E and mfhi in D stall.
// TESTING
//  1 mult 0xFFFFFFFF,2 -> busy 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFE after.
//  2 multu 0xFFFFFFFF,2 -> hi=1, lo=0xFFFFFFFE; d_is_md=1 during busy ->
//    stall_req=1 each cycle, 0 the cycle after busy falls.
//  3 div -7,2 -> 10 busy cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7,0 ->
//    busy 10 cycles, hi/lo unchanged.
//  4 mthi 0x1234, mtlo 0x5678, then mfhi/mflo -> md_rdata 0x1234 / 0x5678.
//  5 div 0x80000000,-1 -> lo=0x80000000, hi=0.
//  6 reset at cycle 3 of a div -> busy=0, hi=lo=0 next cycle, no late write.

Source files
------------

// File: rtl/md_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : md_unit_ctrl
// Description : E-stage multiply/divide sequencer for the pipelined MIPS core.
//               Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo, owns the
//               architectural HI/LO registers, models a fixed multi-cycle
//               latency with a down-counter FSM and asks the D stage to stall
//               while the unit is occupied.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high
//   e_md_op    in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,
//                       7 mthi,8 mtlo, 9-15 none
//   e_rs       in   32  forwarded rs value in E
//   e_rt       in   32  forwarded rt value in E
//   d_is_md    in   1   D-stage instruction is an md op
//   busy       out  1   multi-cycle operation in flight
//   start      out  1   multiply/divide accepted this cycle
//   stall_req  out  1   hold D: md op in D while unit is (or becomes) busy
//   md_rdata   out  32  HI for mfhi, LO for mflo, otherwise 0
//   hi, lo     out  32  architectural HI/LO registers
// ============================================================================
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_md_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_is_md,
    output logic        busy,
    output logic        start,
    output logic        stall_req,
    output logic [31:0] md_rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    // Counter holds "remaining busy cycles minus one", so the load value is N-1
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               done;

    // Results captured at the accepting edge
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_wr;

    // ------------------------------------------------------------------------
    // Op decode
    // ------------------------------------------------------------------------
    logic is_mul;
    logic is_div;
    logic is_signed;
    logic is_idle;
    logic mt_hi;
    logic mt_lo;

    assign is_mul    = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU);
    assign is_div    = (e_md_op == OP_DIV)  || (e_md_op == OP_DIVU);
    assign is_signed = (e_md_op == OP_MULT) || (e_md_op == OP_DIV);
    assign is_idle   = (state == ST_IDLE);

    // Any md op arriving while busy is a protocol violation and is dropped
    assign start = (is_mul || is_div) && is_idle;
    assign mt_hi = (e_md_op == OP_MTHI) && is_idle;
    assign mt_lo = (e_md_op == OP_MTLO) && is_idle;

    assign busy      = (state == ST_BUSY);
    assign stall_req = d_is_md && (start || busy);

    always_comb begin
        md_rdata = 32'd0;
        if (e_md_op == OP_MFHI) begin
            md_rdata = hi;
        end else if (e_md_op == OP_MFLO) begin
            md_rdata = lo;
        end
    end

    // ------------------------------------------------------------------------
    // Multiply: sign/zero extend to 64 bits, low 64 bits of the product are
    // the exact result in both signed and unsigned modes.
    // ------------------------------------------------------------------------
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    assign mul_a   = is_signed ? {{32{e_rs[31]}}, e_rs} : {32'd0, e_rs};
    assign mul_b   = is_signed ? {{32{e_rt[31]}}, e_rt} : {32'd0, e_rt};
    assign product = mul_a * mul_b;

    // ------------------------------------------------------------------------
    // Divide: one unsigned divider on magnitudes, signs re-applied after.
    // Quotient is negative when operand signs differ; remainder follows the
    // dividend. 0x80000000 / -1 falls out naturally: |a| = 0x80000000, the
    // signs match, so the quotient stays 0x80000000 and the remainder is 0.
    // ------------------------------------------------------------------------
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic        div_zero;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] quot;
    logic [31:0] rem;

    assign a_neg    = is_signed && e_rs[31];
    assign b_neg    = is_signed && e_rt[31];
    assign a_mag    = a_neg ? (~e_rs + 32'd1) : e_rs;
    assign b_mag    = b_neg ? (~e_rt + 32'd1) : e_rt;
    assign div_zero = (e_rt == 32'd0);
    // Keep the divider away from x/0; the result is discarded in that case
    assign b_safe   = div_zero ? 32'd1 : b_mag;
    assign uquot    = a_mag / b_safe;
    assign urem     = a_mag % b_safe;
    assign quot     = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
    assign rem      = a_neg ? (~urem + 32'd1) : urem;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    assign res_hi = is_div ? rem  : product[63:32];
    assign res_lo = is_div ? quot : product[31:0];
    // A zero divisor still occupies the unit but leaves HI/LO untouched
    assign res_wr = !(is_div && div_zero);

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_BUSY;
                    cnt_nxt   = is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                    done      = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, pending result and HI/LO registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;

            if (start) begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= res_wr;
            end

            // done only fires when BUSY, mt_* only when IDLE: never together
            if (done && pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (mt_hi) begin
                hi <= e_rs;
            end
            if (mt_lo) begin
                lo <= e_rs;
            end
        end
    end

endmodule
`default_nettype wire
